// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus initiator and its GPIO8 peripheral map.
// No logic here: state encoding, data width and register offsets only.
package mem_bus_pkg;

  localparam int DATA_W = 32;

  // GPIO8 peripheral word offsets
  localparam logic [1:0] GPIO8_ENO = 2'd0;
  localparam logic [1:0] GPIO8_IN  = 2'd1;
  localparam logic [1:0] GPIO8_OUT = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS     = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Bus-wait watchdog: counts stalled BUS cycles, tc flags the cycle that reaches TIMEOUT.
// tc is combinational on the current count and enable; TIMEOUT=0 never fires.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Fires on the stalled cycle that would make the count equal TIMEOUT.
  assign tc = (TIMEOUT != 0) && enable && (cnt == TC_VAL);

endmodule

// File: rtl/mem_initiator.sv
// Single-outstanding bus initiator: request -> bus access -> optional read latency -> response.
// Min 3 cycles per write, 3+RDATA_LAT per read; new requests are held off until the response drains.
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W    = 2,
  parameter int RDATA_LAT = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_wen,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_mem_valid,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam logic [1:0] LAT_LAST = 2'((RDATA_LAT > 0) ? RDATA_LAT - 1 : 0);

  state_t     state;
  logic [1:0] lat_cnt;
  logic       accept;
  logic       tmo_en;
  logic       tmo_tc;

  assign o_req_ready = (state == IDLE);
  assign accept      = i_req_valid && o_req_ready;
  assign tmo_en      = (state == BUS) && !i_mem_ready;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (tmo_en),
    .tc     (tmo_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      o_mem_valid <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wen   <= 1'b0;
      o_mem_wdata <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_mem_addr  <= i_req_addr;
            o_mem_wen   <= i_req_wen;
            o_mem_wdata <= i_req_wdata;
            o_mem_valid <= 1'b1;
            state       <= BUS;
          end
        end
        BUS: begin
          // Ready wins over a coincident timeout terminal count.
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            if (o_mem_wen) begin
              o_rsp_rdata <= '0;
              o_rsp_err   <= 1'b0;
              o_rsp_valid <= 1'b1;
              state       <= RESP;
            end else if (RDATA_LAT == 0) begin
              o_rsp_rdata <= i_mem_rdata;
              o_rsp_err   <= 1'b0;
              o_rsp_valid <= 1'b1;
              state       <= RESP;
            end else begin
              lat_cnt <= '0;
              state   <= WAIT_RD;
            end
          end else if (tmo_tc) begin
            o_mem_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b1;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end
        end
        WAIT_RD: begin
          if (lat_cnt == LAT_LAST) begin
            o_rsp_rdata <= i_mem_rdata;
            o_rsp_err   <= 1'b0;
            o_rsp_valid <= 1'b1;
            state       <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: GPIO8 responder with programmable wait states, plus a register-map
// reference model that predicts response data, error flag and cycle counts per transaction.
module tb_mem_initiator;
  import mem_bus_pkg::*;

  localparam int ADDR_W = 2;
  localparam int LAT    = 1;
  localparam int TMO    = 15;
  localparam int NEVER  = 1000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req_valid = 1'b0;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_req_addr = '0;
  logic              i_req_wen = 1'b0;
  logic [31:0]       i_req_wdata = '0;
  logic              o_mem_valid;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_wen;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_ready;
  logic [31:0]       i_mem_rdata;
  logic              o_rsp_valid;
  logic              i_rsp_ready = 1'b0;
  logic [31:0]       o_rsp_rdata;
  logic              o_rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_initiator #(
    .ADDR_W    (ADDR_W),
    .RDATA_LAT (LAT),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_wen   (i_req_wen),
    .i_req_wdata (i_req_wdata),
    .o_mem_valid (o_mem_valid),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wen   (o_mem_wen),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err)
  );

  // GPIO8 responder: ready after w_cfg wait cycles, read data valid one edge after the handshake,
  // spurious ready and junk data everywhere else.
  int          w_cfg = 0;
  int          bus_cyc = 0;
  logic        noise = 1'b0;
  logic [7:0]  gpio_in = 8'h00;
  logic [7:0]  gpio_eno = 8'h00;
  logic [7:0]  gpio_out = 8'h00;
  logic        rd_flag = 1'b0;
  logic [31:0] rd_hold = '0;
  logic [31:0] junk = '0;

  assign i_mem_ready = o_mem_valid ? (bus_cyc == w_cfg) : noise;
  assign i_mem_rdata = rd_flag ? rd_hold : junk;

  always @(posedge clk) begin
    bus_cyc <= o_mem_valid ? bus_cyc + 1 : 0;
    junk    <= $urandom;
    rd_flag <= 1'b0;
    if (o_mem_valid && i_mem_ready) begin
      if (o_mem_wen) begin
        if (o_mem_addr == GPIO8_ENO) gpio_eno <= o_mem_wdata[7:0];
        else if (o_mem_addr == GPIO8_OUT) gpio_out <= o_mem_wdata[7:0];
      end else begin
        rd_flag <= 1'b1;
        case (o_mem_addr)
          GPIO8_ENO: rd_hold <= {24'h0, gpio_eno};
          GPIO8_IN:  rd_hold <= {24'h0, gpio_in};
          GPIO8_OUT: rd_hold <= {24'h0, gpio_out};
          default:   rd_hold <= 32'h0;
        endcase
      end
    end
  end

  // Reference register map (what a correct bus would have written so far)
  logic [7:0] m_regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input logic [1:0] a, input logic we, input logic [31:0] wd,
                         input int w, input int bp);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_hi;
    int          lat;
    int          hi;
    logic        stable;

    exp_err = (w >= TMO);
    exp_hi  = exp_err ? TMO : w + 1;
    exp_lat = exp_err ? TMO : 1 + w + (we ? 0 : LAT);
    exp_rd  = 32'h0;
    if (!exp_err) begin
      if (we) begin
        if (a == 2'd0 || a == 2'd2) m_regs[a] = wd[7:0];
      end else begin
        exp_rd = (a == 2'd1) ? {24'h0, gpio_in} : (a == 2'd3) ? 32'h0 : {24'h0, m_regs[a]};
      end
    end

    w_cfg       = w;
    i_req_addr  = a;
    i_req_wen   = we;
    i_req_wdata = wd;
    i_req_valid = 1'b1;
    chk("req_ready_idle", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    i_req_addr  = 2'($urandom);
    i_req_wen   = 1'($urandom);
    i_req_wdata = $urandom;
    noise       = 1'($urandom);
    chk("mem_valid_t1", 32'(o_mem_valid), 32'd1);
    chk("mem_addr", 32'(o_mem_addr), 32'(a));
    chk("mem_wen", 32'(o_mem_wen), 32'(we));
    chk("mem_wdata", o_mem_wdata, wd);

    lat = 0;
    hi = 1;
    stable = 1'b1;
    while (!o_rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      noise = 1'($urandom);
      if (o_mem_valid) begin
        hi++;
        if (o_mem_addr !== a || o_mem_wen !== we || o_mem_wdata !== wd) stable = 1'b0;
      end
      if (o_req_ready) stable = 1'b0;
    end
    chk("rsp_arrived", 32'(o_rsp_valid), 32'd1);
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("mem_valid_cycles", 32'(hi), 32'(exp_hi));
    chk("bus_stable", 32'(stable), 32'd1);
    chk("mem_valid_dropped", 32'(o_mem_valid), 32'd0);
    chk("rsp_rdata", o_rsp_rdata, exp_rd);
    chk("rsp_err", 32'(o_rsp_err), 32'(exp_err));

    stable = 1'b1;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      noise = 1'($urandom);
      if (!o_rsp_valid || o_rsp_rdata !== exp_rd || o_rsp_err !== exp_err || o_req_ready)
        stable = 1'b0;
    end
    if (bp > 0) chk("rsp_backpressure_hold", 32'(stable), 32'd1);

    i_rsp_ready = 1'b1;
    @(posedge clk); #1;
    i_rsp_ready = 1'b0;
    chk("rsp_drained", 32'(o_rsp_valid), 32'd0);
    chk("req_ready_after_drain", 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    logic [1:0] ra;
    logic       rw;
    int         rwait;
    logic       seen;

    // Reset values
    #1;
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_mem_valid", 32'(o_mem_valid), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_mem_wen", 32'(o_mem_wen), 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_post_rst", 32'(o_req_ready), 32'd1);

    // Write ENO then read it back
    run_txn(2'd0, 1'b1, 32'h0000_00A5, 0, 0);
    run_txn(2'd0, 1'b0, 32'h0, 0, 0);

    // Read IN with two wait states: response 4 edges after accept
    gpio_in = 8'h3C;
    run_txn(2'd1, 1'b0, 32'h0, 2, 0);

    // Timeout on a write that is never acknowledged; OUT must stay unwritten
    run_txn(2'd2, 1'b1, 32'h0000_0077, NEVER, 0);
    run_txn(2'd2, 1'b0, 32'h0, 0, 0);

    // Ready in the terminal BUS cycle wins; one cycle later is a timeout
    run_txn(2'd0, 1'b0, 32'h0, TMO - 1, 0);
    run_txn(2'd0, 1'b0, 32'h0, TMO, 0);

    // Response backpressure, then the next request
    run_txn(2'd2, 1'b1, 32'h0000_005A, 1, 5);
    run_txn(2'd2, 1'b0, 32'h0, 0, 2);

    // Reset during the second BUS cycle aborts without a response
    w_cfg       = NEVER;
    i_req_addr  = 2'd0;
    i_req_wen   = 1'b1;
    i_req_wdata = 32'h0000_00FF;
    i_req_valid = 1'b1;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_bus_valid", 32'(o_mem_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_valid", 32'(o_mem_valid), 32'd0);
    chk("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("abort_mem_addr", 32'(o_mem_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_req_ready", 32'(o_req_ready), 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (o_rsp_valid || o_mem_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    run_txn(2'd0, 1'b0, 32'h0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      ra      = 2'($urandom);
      rw      = 1'($urandom);
      rwait   = ($urandom_range(0, 7) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 3);
      gpio_in = 8'($urandom);
      run_txn(ra, rw, $urandom, rwait, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter ADDR_W, default 2, width of the peripheral word address.
REQ-002 Parameter RDATA_LAT, default 1, cycles from the bus handshake until i_mem_rdata is valid; legal range 0..3.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles o_mem_valid waits for i_mem_ready; 0 disables the timeout; legal range 0..255.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 i_req_valid  in  1  upstream command present.
REQ-007 o_req_ready  out  1  command accepted when high with i_req_valid.
REQ-008 i_req_addr  in  ADDR_W  target word address.
REQ-009 i_req_wen  in  1  1=write, 0=read.
REQ-010 i_req_wdata  in  32  write data.
REQ-011 o_mem_valid  out  1  bus access active.
REQ-012 o_mem_addr  out  ADDR_W  bus address.
REQ-013 o_mem_wen  out  1  bus write enable.
REQ-014 o_mem_wdata  out  32  bus write data.
REQ-015 i_mem_ready  in  1  responder completes the access.
REQ-016 i_mem_rdata  in  32  responder read data.
REQ-017 o_rsp_valid  out  1  response available.
REQ-018 i_rsp_ready  in  1  upstream consumes the response.
REQ-019 o_rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-020 o_rsp_err  out  1  access timed out.

Function
REQ-021 FSM states SHALL be IDLE, BUS, WAIT_RD, RESP; one access in flight at a time.
REQ-022 o_req_ready SHALL be 1 exactly in IDLE, combinationally.
REQ-023 On i_req_valid&&o_req_ready at edge T, addr/wen/wdata SHALL be registered and o_mem_valid=1 from T+1 (state BUS).
REQ-024 All o_mem_* outputs SHALL be registered and stable while o_mem_valid=1.
REQ-025 In BUS, the bus handshake is o_mem_valid&&i_mem_ready at an edge; o_mem_valid SHALL be 0 the cycle after.
REQ-026 Write handshake SHALL go to RESP with rdata=0, err=0.
REQ-027 Read handshake with RDATA_LAT=0 SHALL capture i_mem_rdata at the handshake edge and go to RESP.
REQ-028 Read handshake with RDATA_LAT=N>0 SHALL go to WAIT_RD for N cycles, capture i_mem_rdata at the Nth edge, then go to RESP.
REQ-029 A timeout counter SHALL clear on entry to BUS and increment each BUS cycle without i_mem_ready; when it reaches TIMEOUT (TIMEOUT>0), drop o_mem_valid and go to RESP with err=1, rdata=0.
REQ-030 i_mem_ready at the same edge as the timeout terminal count SHALL take precedence (normal completion, err=0).
REQ-031 In RESP, o_rsp_valid=1 with stable rdata/err until i_rsp_ready; then return to IDLE.
REQ-032 Back-to-back: minimum 3 cycles per write, 3+RDATA_LAT per read with immediate i_mem_ready and i_rsp_ready.
REQ-033 i_mem_ready outside BUS and i_mem_rdata outside the capture edge SHALL be ignored.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, timeout/latency counters 0, o_mem_valid=0, o_mem_addr=0, o_mem_wen=0, o_mem_wdata=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
REQ-035 Reset mid-access SHALL abort it without a response; o_req_ready=1 from the first edge after rst_n rises.

Structure
REQ-036 Package mem_bus_pkg SHALL hold the state enum, DATA_W=32, and the GPIO8 map constants (ENO=0, IN=1, OUT=2).
REQ-037 One sub-module, mem_timeout_cnt (clear/enable/terminal-count), SHALL implement REQ-029; all else is flat.

Verification
REQ-038 Write ENO: req addr=0 wen=1 wdata=0x000000A5 against a GPIO8 responder -> one bus cycle, rsp err=0 rdata=0, later read addr=0 returns 0x000000A5.
REQ-039 Read IN, RDATA_LAT=1: gpio_in=0x3C held -> rsp rdata=0x0000003C, err=0, rsp_valid 4 cycles after req accept.
REQ-040 Timeout: TIMEOUT=15, i_mem_ready tied 0 -> o_mem_valid high for 15 cycles, rsp err=1 rdata=0.
REQ-041 Ready on terminal cycle: i_mem_ready asserted in the 15th BUS cycle -> err=0.
REQ-042 Backpressure: i_rsp_ready low 5 cycles -> rsp held stable, o_req_ready=0, next req accepted after the drain.
REQ-043 Reset mid-BUS: rst_n low in BUS cycle 2 -> o_mem_valid=0 immediately, no rsp, new request completes normally.
